// File: rtl/proc_pc_rf.sv
// Program counter plus 32 x 64-bit register file with two asynchronous read
// ports and one clocked write port. Reset is active-high despite the nrst name.
module proc_pc_rf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] new_pc,
  input  logic        pc_src,
  output logic [31:0] pc,
  input  logic        reg_write,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [63:0] wdata,
  output logic [63:0] rdata1,
  output logic [63:0] rdata2
);

  localparam logic [31:0] PC_INC = 32'(PC_STEP);

  logic [31:0] pc_q, pc_d;
  logic [63:0] regs_q [32];
  logic [63:0] regs_d [32];

  always_comb begin
    pc_d = pc_src ? new_pc : pc_q + PC_INC;
  end

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_comb begin
    regs_d = regs_q;
    if (reg_write && (rd != 5'd0)) begin
      regs_d[rd] = wdata;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      pc_q   <= RESET_PC;
      regs_q <= '{default: '0};
    end else begin
      pc_q   <= pc_d;
      regs_q <= regs_d;
    end
  end

  assign pc     = pc_q;
  assign rdata1 = regs_q[rs1];
  assign rdata2 = regs_q[rs2];

endmodule

// File: tb/tb_proc_pc_rf.sv
// Directed and randomized checks of proc_pc_rf against a behavioural model of
// the PC and register file.
module tb_proc_pc_rf;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] new_pc;
  logic        pc_src;
  logic [31:0] pc;
  logic        reg_write;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] wdata;
  logic [63:0] rdata1, rdata2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] pc_m;
  logic [63:0] regs_m [32];

  proc_pc_rf dut (
    .clk       (clk),
    .nrst      (nrst),
    .new_pc    (new_pc),
    .pc_src    (pc_src),
    .pc        (pc),
    .reg_write (reg_write),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .wdata     (wdata),
    .rdata1    (rdata1),
    .rdata2    (rdata2)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] mread(input logic [4:0] idx);
    return (idx == 5'd0) ? 64'h0 : regs_m[idx];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic model_reset();
    pc_m = 32'h0;
    for (int i = 0; i < 32; i++) regs_m[i] = 64'h0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pc"}, {32'h0, pc}, {32'h0, pc_m});
    check({tag, "_rd1"}, rdata1, mread(rs1));
    check({tag, "_rd2"}, rdata2, mread(rs2));
  endtask

  // One clock with the currently driven inputs; reads checked before and after the edge.
  task automatic cycle(input string tag);
    #1;
    check({tag, "_pre"}, rdata1, mread(rs1));
    @(posedge clk);
    if (nrst) model_reset();
    else begin
      if (reg_write && rd != 5'd0) regs_m[rd] = wdata;
      pc_m = pc_src ? new_pc : pc_m + 32'd4;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic src, input logic [31:0] npc, input logic we,
                       input logic [4:0] d, input logic [63:0] wd,
                       input logic [4:0] a, input logic [4:0] b);
    pc_src = src; new_pc = npc; reg_write = we; rd = d; wdata = wd; rs1 = a; rs2 = b;
  endtask

  initial begin
    nrst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    model_reset();
    #2;
    check("reset_pc_async", {32'h0, pc}, 64'h0);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      check("reset_regs_r1", rdata1, 64'h0);
      check("reset_regs_r2", rdata2, 64'h0);
    end
    // Edges during reset, even with pending branch/write, change nothing.
    drive(1'b1, 32'h1234, 1'b1, 5'd9, 64'hABCD, 5'd9, 5'd0);
    cycle("in_reset_a");
    cycle("in_reset_b");
    @(negedge clk);
    nrst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 64'h0, 5'd9, 5'd0);

    // Sequential increment 0,4,8,12
    check("seq_start", {32'h0, pc}, 64'h0);
    cycle("seq1"); check("seq1_val", {32'h0, pc}, 64'h4);
    cycle("seq2"); check("seq2_val", {32'h0, pc}, 64'h8);
    cycle("seq3"); check("seq3_val", {32'h0, pc}, 64'hC);

    @(negedge clk);
    drive(1'b1, 32'h40, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    cycle("branch"); check("branch_val", {32'h0, pc}, 64'h40);
    @(negedge clk);
    pc_src = 1'b0;
    cycle("after_branch"); check("after_branch_val", {32'h0, pc}, 64'h44);

    // Write x5, read it back with x0 on the other port
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd5, 5'd0);
    cycle("wr_x5");
    check("x5_val", rdata1, 64'hDEAD_BEEF_0123_4567);
    check("x0_other", rdata2, 64'h0);

    // Writes to x0 are discarded
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
    cycle("wr_x0");
    check("x0_stays0", rdata1, 64'h0);

    // No bypass: old value before the edge, new value after
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 5'd7, 64'h1, 5'd7, 5'd7);
    cycle("x7_init");
    @(negedge clk);
    wdata = 64'h2;
    #1;
    check("nobypass_before", rdata1, 64'h1);
    cycle("x7_upd");
    check("nobypass_after", rdata1, 64'h2);
    check("same_index_r2", rdata2, 64'h2);

    // Wrap-around and verbatim misaligned target
    @(negedge clk);
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0, 64'h0, 5'd5, 5'd7);
    cycle("to_top");
    @(negedge clk);
    pc_src = 1'b0;
    cycle("wrap"); check("wrap_val", {32'h0, pc}, 64'h0);
    @(negedge clk);
    drive(1'b1, 32'h13, 1'b1, 5'd12, 64'h77, 5'd12, 5'd5);
    cycle("misaligned_and_write"); check("misaligned_val", {32'h0, pc}, 64'h13);
    @(negedge clk);
    pc_src = 1'b0; reg_write = 1'b0;
    cycle("misaligned_inc"); check("misaligned_inc_val", {32'h0, pc}, 64'h17);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), {$urandom, $urandom},
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cycle("rand");
    end

    // Mid-cycle reset clears everything immediately and overrides pending updates
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 5'd3, 64'h55, 5'd3, 5'd0);
    cycle("x3_write");
    @(negedge clk);
    drive(1'b1, 32'h20, 1'b0, 5'd0, 64'h0, 5'd3, 5'd0);
    cycle("pc_20");
    check("pc_20_val", {32'h0, pc}, 64'h20);
    check("x3_val", rdata1, 64'h55);
    @(negedge clk);
    drive(1'b1, 32'h80, 1'b1, 5'd3, 64'h99, 5'd3, 5'd3);
    #2;
    nrst = 1'b1;
    model_reset();
    #1;
    check("async_rst_pc", {32'h0, pc}, 64'h0);
    check("async_rst_x3", rdata1, 64'h0);
    cycle("rst_hold");
    @(negedge clk);
    nrst = 1'b0;
    drive(1'b0, 32'h80, 1'b0, 5'd0, 64'h0, 5'd3, 5'd0);
    cycle("post_rst_first");
    check("post_rst_first_val", {32'h0, pc}, 64'h4);
    check("post_rst_x3", rdata1, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/proc_pc_rf.md
PROC_PC_RF -- requirements
Module: proc_pc_rf

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded by reset.
REQ-002 Parameter PC_STEP, default 4: sequential PC increment in bytes.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 nrst  input  1  reset, asynchronous and active-high (asserted = 1) despite the name.
REQ-005 new_pc  input  32  branch/jump target PC.
REQ-006 pc_src  input  1  1 = load new_pc at next edge; 0 = sequential increment.
REQ-007 pc  output  32  current PC, driven directly from the PC register.
REQ-008 reg_write  input  1  register-file write enable.
REQ-009 rs1  input  5  read-port-1 register index.
REQ-010 rs2  input  5  read-port-2 register index.
REQ-011 rd  input  5  write-port register index.
REQ-012 wdata  input  64  write data.
REQ-013 rdata1  output  64  contents of register rs1.
REQ-014 rdata2  output  64  contents of register rs2.

Function
REQ-015 PC: 32-bit register; at each rising clk with reset deasserted, pc <= new_pc if pc_src=1, else pc <= pc + PC_STEP.
REQ-016 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
REQ-017 new_pc is loaded verbatim; no alignment masking or misalignment checking.
REQ-018 PC has no stall/enable; it advances every cycle out of reset.
REQ-019 Register file: 32 registers x0..x31, each 64 bits.
REQ-020 Reads are combinational and asynchronous: rdata1 = reg[rs1], rdata2 = reg[rs2], updating in the same cycle the index changes.
REQ-021 x0 reads as 64'h0 always; writes with rd=0 are discarded.
REQ-022 Write: at rising clk, if reg_write=1 and rd!=0, reg[rd] <= wdata; otherwise no register changes.
REQ-023 No write-to-read bypass: a read of the register being written returns the old value until the edge, the new value after it.
REQ-024 rs1=rs2 is legal; both ports return the same value.
REQ-025 PC and register file are independent; pc_src and reg_write may be active in the same cycle, both updates taking effect at that edge.
REQ-026 No X propagation from unwritten registers: every register has a defined value from reset.

Reset
REQ-027 While nrst=1: pc = RESET_PC and all 32 registers = 64'h0, taking effect immediately without a clock edge.
REQ-028 Assertion mid-operation overrides any pending pc_src or reg_write; no write of that cycle survives.
REQ-029 Rising edges during reset change nothing; after deassertion the first rising edge yields pc = RESET_PC + 4 (pc_src=0) or new_pc (pc_src=1).
REQ-030 After reset, rdata1/rdata2 = 0 for every index until written.

Verification
REQ-031 Reset then 3 edges with pc_src=0 -> pc sequence 0, 4, 8, 12.
REQ-032 pc=8, pc_src=1, new_pc=32'h40 -> pc=32'h40 after edge; next edge with pc_src=0 -> 32'h44.
REQ-033 reg_write=1, rd=5, wdata=64'hDEAD_BEEF_0123_4567, then rs1=5, rs2=0 -> rdata1=64'hDEAD_BEEF_0123_4567, rdata2=0.
REQ-034 reg_write=1, rd=0, wdata=64'hFFFF_FFFF_FFFF_FFFF -> rdata1 with rs1=0 stays 0.
REQ-035 rs1=rd=7, reg[7]=1, wdata=2, reg_write=1 -> rdata1=1 before edge, 2 after.
REQ-036 Write x3=64'h55, pc=32'h20, then nrst=1 between edges -> pc=0 and rdata1(rs1=3)=0 immediately, without waiting for clk.
